// File: rtl/vga_bounce_gen_if.sv
// Pixel bus between the VGA driver (master) and a pixel source (slave):
// next-pixel coordinates out of the driver, registered colour back into it.
interface vga_bounce_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] red_out;
  logic [7:0] green_out;
  logic [7:0] blue_out;

  modport master (output x, y, input red_out, green_out, blue_out);
  modport slave  (input x, y, output red_out, green_out, blue_out);
endinterface

// File: rtl/vga_bounce_gen.sv
// Bouncing square sprite pixel source with pause and frame-synchronous load.
// Define CHECKER_BG_EN to replace the solid background with a 32-px checkerboard.
module vga_bounce_gen #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          SIZE       = 32,
  parameter int          STEP       = 2,
  parameter logic [23:0] SPRITE_RGB = 24'hFF2000,
  parameter logic [23:0] BG_RGB     = 24'h101010
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_bounce_gen_if.slave      pix,
  input  logic                 pause,
  input  logic                 load,
  input  logic [9:0]           load_x,
  input  logic [9:0]           load_y,
  output logic                 frame_pulse,
  output logic [15:0]          bounce_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;

  localparam logic [9:0]  X_LIM   = 10'(H_RES - SIZE);
  localparam logic [9:0]  Y_LIM   = 10'(V_RES - SIZE);
  localparam logic [9:0]  X_EOF   = 10'(H_RES - 1);
  localparam logic [9:0]  Y_EOF   = 10'(V_RES - 1);
  localparam logic [10:0] SIZE_W  = 11'(SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [9:0]  STEP_10 = 10'(STEP);

  logic [1:0]  state;
  logic [9:0]  pos_x, pos_y;
  logic        neg_x, neg_y;
  logic        pending;
  logic [9:0]  sh_x, sh_y;

  logic        eof_p0, in_x_p0, in_y_p0;
  logic [23:0] bg_p0, rgb_p0;
  logic [23:0] rgb_p1;
  logic        frame_p1;

  logic [9:0]  nx_pos_x, nx_pos_y;
  logic        nx_neg_x, nx_neg_y;
  logic        bnc_x, bnc_y;
  logic        apply_now, do_step;

  // Returns {bounced, new_dir_negative, new_pos}; lim is RES-SIZE.
  function automatic logic [11:0] step_axis(input logic [9:0] pos,
                                            input logic       neg,
                                            input logic [9:0] lim);
    logic [11:0] r;
    if (!neg && (({1'b0, pos} + STEP_W) > {1'b0, lim}))
      r = {1'b1, 1'b1, lim};
    else if (neg && ({1'b0, pos} < STEP_W))
      r = {1'b1, 1'b0, 10'd0};
    else if (neg)
      r = {1'b0, 1'b1, pos - STEP_10};
    else
      r = {1'b0, 1'b0, pos + STEP_10};
    return r;
  endfunction

  function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

`ifdef CHECKER_BG_EN
  function automatic logic [7:0] sat_shl2(input logic [7:0] c);
    return (c > 8'd63) ? 8'hFF : {c[5:0], 2'b00};
  endfunction
`endif

  // Stage p0: decode the presented coordinate against the current sprite position
  always_comb begin
    eof_p0  = (pix.x == X_EOF) && (pix.y == Y_EOF);
    in_x_p0 = ({1'b0, pix.x} >= {1'b0, pos_x}) && ({1'b0, pix.x} < ({1'b0, pos_x} + SIZE_W));
    in_y_p0 = ({1'b0, pix.y} >= {1'b0, pos_y}) && ({1'b0, pix.y} < ({1'b0, pos_y} + SIZE_W));
`ifdef CHECKER_BG_EN
    bg_p0 = (pix.x[5] ^ pix.y[5]) ? BG_RGB
          : {sat_shl2(BG_RGB[23:16]), sat_shl2(BG_RGB[15:8]), sat_shl2(BG_RGB[7:0])};
`else
    bg_p0 = BG_RGB;
`endif
    rgb_p0 = (in_x_p0 && in_y_p0) ? SPRITE_RGB : bg_p0;
  end

  always_comb begin
    {bnc_x, nx_neg_x, nx_pos_x} = step_axis(pos_x, neg_x, X_LIM);
    {bnc_y, nx_neg_y, nx_pos_y} = step_axis(pos_y, neg_y, Y_LIM);
    apply_now = (state == ST_RUN) && !pause && eof_p0 && pending;
    do_step   = (state == ST_RUN) && !pause && eof_p0 && !pending;
  end

  // Stage p1: registered colour and frame pulse; motion updates only on eof
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      pos_x        <= 10'd0;
      pos_y        <= 10'd0;
      neg_x        <= 1'b0;
      neg_y        <= 1'b0;
      pending      <= 1'b0;
      bounce_count <= 16'd0;
      frame_p1     <= 1'b0;
      rgb_p1       <= 24'd0;
    end else begin
      frame_p1 <= eof_p0;
      rgb_p1   <= rgb_p0;
      // A strobe coinciding with an apply is kept for the following eof.
      pending  <= load | (pending & ~apply_now);
      if (apply_now) begin
        pos_x <= sh_x;
        pos_y <= sh_y;
      end else if (do_step) begin
        pos_x        <= nx_pos_x;
        pos_y        <= nx_pos_y;
        neg_x        <= nx_neg_x;
        neg_y        <= nx_neg_y;
        bounce_count <= bounce_count + {15'd0, bnc_x} + {15'd0, bnc_y};
      end
      case (state)
        ST_RUN: begin
          if (pause)          state <= ST_PAUSED;
          else if (apply_now) state <= ST_APPLY;
        end
        ST_PAUSED: if (eof_p0 && !pause) state <= ST_RUN;
        ST_APPLY:  state <= pause ? ST_PAUSED : ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sh_x <= clamp_pos(load_x, X_LIM);
      sh_y <= clamp_pos(load_y, Y_LIM);
    end
  end

  assign pix.red_out   = rgb_p1[23:16];
  assign pix.green_out = rgb_p1[15:8];
  assign pix.blue_out  = rgb_p1[7:0];
  assign frame_pulse   = frame_p1;

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Scoreboard bench for vga_bounce_gen: a per-cycle behavioural model predicts
// colour, frame pulse and bounce count; a monitor compares one cycle later.
module tb_vga_bounce_gen;
  localparam int          H_RES      = 640;
  localparam int          V_RES      = 480;
  localparam int          SIZE       = 32;
  localparam int          STEP       = 2;
  localparam logic [23:0] SPRITE_RGB = 24'hFF2000;
  localparam logic [23:0] BG_RGB     = 24'h101010;

  logic        clk;
  logic        reset;
  logic        pause, load;
  logic [9:0]  load_x, load_y;
  logic        frame_pulse;
  logic [15:0] bounce_count;

  vga_bounce_gen_if vif ();

  vga_bounce_gen #(
    .H_RES(H_RES), .V_RES(V_RES), .SIZE(SIZE), .STEP(STEP),
    .SPRITE_RGB(SPRITE_RGB), .BG_RGB(BG_RGB)
  ) dut (
    .clk(clk), .reset(reset), .pix(vif), .pause(pause), .load(load),
    .load_x(load_x), .load_y(load_y), .frame_pulse(frame_pulse),
    .bounce_count(bounce_count)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        fp;
    logic [15:0] bc;
  } exp_t;

  typedef enum {RUNNING, FROZEN, LOADING} mode_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    failures = 0;
  int    fp_seen = 0;
  int    fp_model = 0;
  bit    pz_v = 1'b0;

  mode_t mmode;
  int    mpx, mpy, mdx, mdy, mbc, shx, shy;
  bit    mpend;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] boost(input logic [7:0] c);
    int v;
    v = int'(c) * 4;
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  function automatic logic [23:0] model_rgb(input int x, input int y);
    logic [23:0] bg;
    if (x >= mpx && x < mpx + SIZE && y >= mpy && y < mpy + SIZE) return SPRITE_RGB;
`ifdef CHECKER_BG_EN
    bg = BG_RGB;
    if ((((x / 32) + (y / 32)) % 2) == 1) return bg;
    return {boost(bg[23:16]), boost(bg[15:8]), boost(bg[7:0])};
`else
    bg = BG_RGB;
    return bg;
`endif
  endfunction

  task automatic model_reset();
    mmode = RUNNING;
    mpx = 0; mpy = 0; mdx = 1; mdy = 1;
    mbc = 0; mpend = 0; shx = 0; shy = 0;
  endtask

  task automatic move_axis(inout int p, inout int d, input int res);
    if (d > 0 && p + SIZE + STEP > res) begin
      p = res - SIZE; d = -1; mbc = (mbc + 1) % 65536;
    end else if (d < 0 && p < STEP) begin
      p = 0; d = 1; mbc = (mbc + 1) % 65536;
    end else begin
      p = p + d * STEP;
    end
  endtask

  // Drive one pixel on the falling edge and predict the DUT's response.
  task automatic pix(input int x, input int y, input bit ld = 0,
                     input int lx = 0, input int ly = 0);
    exp_t e;
    bit   eof;
    @(negedge clk);
    vif.x  = 10'(x);
    vif.y  = 10'(y);
    pause  = pz_v;
    load   = ld;
    load_x = 10'(lx);
    load_y = 10'(ly);
    e.x   = x;
    e.y   = y;
    e.rgb = model_rgb(x, y);
    eof   = (x == H_RES - 1) && (y == V_RES - 1);
    case (mmode)
      RUNNING: begin
        if (pz_v) mmode = FROZEN;
        else if (eof) begin
          if (mpend) begin
            mpx = shx; mpy = shy; mpend = 0; mmode = LOADING;
          end else begin
            move_axis(mpx, mdx, H_RES);
            move_axis(mpy, mdy, V_RES);
          end
        end
      end
      FROZEN:  if (eof && !pz_v) mmode = RUNNING;
      LOADING: mmode = pz_v ? FROZEN : RUNNING;
      default: mmode = RUNNING;
    endcase
    if (ld) begin
      shx = (lx > H_RES - SIZE) ? H_RES - SIZE : lx;
      shy = (ly > V_RES - SIZE) ? V_RES - SIZE : ly;
      mpend = 1;
    end
    e.fp = eof;
    if (eof) fp_model++;
    e.bc = 16'(mbc);
    sbq.push_back(e);
  endtask

  task automatic rand_pix(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = mpx + int'($urandom_range(0, SIZE + 7)) - 4;
        y = mpy + int'($urandom_range(0, SIZE + 7)) - 4;
      end else begin
        x = int'($urandom_range(0, H_RES - 1));
        y = int'($urandom_range(0, V_RES - 1));
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if (x > H_RES - 1) x = H_RES - 1;
      if (y > V_RES - 1) y = V_RES - 1;
      if (x == H_RES - 1 && y == V_RES - 1) x = 0;
      pix(x, y);
    end
  endtask

  // Sample both sides of each sprite edge at the predicted position.
  task automatic probe();
    int px, py;
    int xs[6];
    int ys[6];
    px = mpx; py = mpy;
    xs = '{px, px + SIZE - 1, px - 1, px + SIZE, px, px + SIZE - 1};
    ys = '{py, py + SIZE - 1, py, py + SIZE - 1, py - 1, py + SIZE};
    for (int i = 0; i < 6; i++) begin
      if (xs[i] >= 0 && xs[i] < H_RES && ys[i] >= 0 && ys[i] < V_RES &&
          !(xs[i] == H_RES - 1 && ys[i] == V_RES - 1))
        pix(xs[i], ys[i]);
    end
  endtask

  task automatic frame(input int n);
    rand_pix(n);
    pix(H_RES - 1, V_RES - 1);
    rand_pix(1);
    probe();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("rgb@%0d,%0d", e.x, e.y),
              {vif.red_out, vif.green_out, vif.blue_out}, e.rgb);
        check($sformatf("frame_pulse@%0d,%0d", e.x, e.y), frame_pulse, e.fp);
        check($sformatf("bounce_count@%0d,%0d", e.x, e.y), bounce_count, e.bc);
        if (frame_pulse) fp_seen++;
      end
    end
  end

  initial begin : stim
    int r, x, y;
    reset = 1'b0; pause = 1'b0; load = 1'b0; load_x = '0; load_y = '0;
    vif.x = '0; vif.y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {vif.red_out, vif.green_out, vif.blue_out}, 24'h0);
    check("reset_frame_pulse", frame_pulse, 1'b0);
    check("reset_bounce_count", bounce_count, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    pix(5, 5);
    pix(100, 100);

    repeat (3) frame(6);
    pix(6, 6); pix(5, 6); pix(37, 37); pix(38, 38);
    @(posedge clk); #2;
    check("three_frame_pulses", fp_seen, fp_model);

    rand_pix(3); pix(200, 100, 1, 607, 200);
    frame(4);
    frame(4);
    frame(4);

    rand_pix(2); pix(10, 10, 1, 900, 470);
    frame(3);

    pz_v = 1'b1;
    repeat (4) frame(5);
    pz_v = 1'b0;
    frame(3);
    frame(3);

    rand_pix(3); pix(H_RES - 1, V_RES - 1, 1, 100, 100);
    rand_pix(1); probe();
    frame(3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) pz_v = ~pz_v;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        x = int'($urandom_range(0, H_RES - 2));
        y = int'($urandom_range(0, V_RES - 1));
        pix(x, y, 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      end else if (r < 12) begin
        pix(H_RES - 1, V_RES - 1);
        rand_pix(1);
      end else begin
        rand_pix(1);
      end
    end

    pz_v = 1'b0;
    frame(2);
    frame(2);
    rand_pix(2); pix(50, 50, 1, 300, 300);
    frame(2);
    pix(310, 310);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_reset_rgb", {vif.red_out, vif.green_out, vif.blue_out}, 24'h0);
    check("async_reset_frame_pulse", frame_pulse, 1'b0);
    check("async_reset_bounce_count", bounce_count, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pix(0, 0); pix(31, 31); pix(32, 0); pix(300, 300);
    frame(3);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sbq.size(), 0);
    check("frame_pulse_total", fp_seen, fp_model);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
